// File: rtl/xor_puf_eval_ctrl.sv
// XOR arbiter PUF evaluation sequencer.
// Latches a challenge and runs EVALS rounds of clear/launch/settle/sample.
// Each round XOR-reduces the K arbiter bits. The controller returns a majority-voted
// response, a stability flag and the count of rounds whose XOR result was 1.
module xor_puf_eval_ctrl #(
    parameter int unsigned N      = 128,
    parameter int unsigned K      = 4,
    parameter int unsigned SETTLE = 8,
    parameter int unsigned EVALS  = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         chal_valid,
    output logic                         chal_ready,
    input  logic [N-1:0]                 chal,
    output logic [N-1:0]                 sel,
    output logic                         arb_clr,
    output logic                         launch,
    input  logic [K-1:0]                 arb,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp,
    output logic                         resp_stable,
    output logic [$clog2(EVALS+1)-1:0]   resp_ones,
    output logic [K-1:0]                 resp_raw
);

    localparam int unsigned OnesW  = $clog2(EVALS + 1);
    localparam int unsigned RoundW = (EVALS > 1) ? $clog2(EVALS) : 1;
    localparam int unsigned CntW   = $clog2(SETTLE + 1);

    localparam logic [RoundW-1:0] LastRound  = RoundW'(EVALS - 1);
    localparam logic [CntW-1:0]   SettleLoad = CntW'(SETTLE);
    localparam logic [OnesW-1:0]  HalfEvals  = OnesW'(EVALS / 2);
    localparam logic [OnesW-1:0]  AllEvals   = OnesW'(EVALS);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLaunch,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [N-1:0]        sel_q, sel_d;
    logic [RoundW-1:0]   round_q, round_d;
    logic [OnesW-1:0]    ones_q, ones_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [K-1:0]        raw_q, raw_d;
    logic                chal_ready_q, chal_ready_d;
    logic                arb_clr_q, arb_clr_d;
    logic                launch_q, launch_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_q, resp_d;
    logic                resp_stable_q, resp_stable_d;
    logic [OnesW-1:0]    resp_ones_q, resp_ones_d;

    // Next-state sequencing, plus the outputs precomputed from the next state so they come
    // straight from flops.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        round_d  = round_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        raw_d    = raw_q;

        unique case (state_q)
            StIdle: begin
                // chal_ready is 1 throughout IDLE, so chal_valid alone completes the handshake.
                if (chal_valid) begin
                    sel_d   = chal;
                    ones_d  = '0;
                    round_d = '0;
                    state_d = StClear;
                end
            end
            StClear:  state_d = StLaunch;
            StLaunch: begin
                cnt_d   = SettleLoad;
                state_d = StSettle;
            end
            StSettle: begin
                // The counter is loaded with SETTLE and leaves on 1, giving exactly SETTLE cycles.
                if (cnt_q == CntW'(1)) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StSample: begin
                ones_d = ones_q + OnesW'(^arb);
                raw_d  = arb;
                if (round_q == LastRound) begin
                    state_d = StDone;
                end else begin
                    round_d = round_q + RoundW'(1);
                    state_d = StClear;
                end
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        chal_ready_d  = (state_d == StIdle);
        arb_clr_d     = (state_d == StClear);
        launch_d      = (state_d == StLaunch);
        resp_valid_d  = (state_d == StDone);
        resp_d        = resp_valid_d & (ones_d > HalfEvals);
        resp_stable_d = resp_valid_d & ((ones_d == '0) || (ones_d == AllEvals));
        resp_ones_d   = resp_valid_d ? ones_d : '0;
    end

    // State and registered outputs; an asynchronous reset abandons any evaluation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            sel_q         <= '0;
            round_q       <= '0;
            ones_q        <= '0;
            cnt_q         <= '0;
            raw_q         <= '0;
            chal_ready_q  <= 1'b1;
            arb_clr_q     <= 1'b0;
            launch_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_q        <= 1'b0;
            resp_stable_q <= 1'b0;
            resp_ones_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            round_q       <= round_d;
            ones_q        <= ones_d;
            cnt_q         <= cnt_d;
            raw_q         <= raw_d;
            chal_ready_q  <= chal_ready_d;
            arb_clr_q     <= arb_clr_d;
            launch_q      <= launch_d;
            resp_valid_q  <= resp_valid_d;
            resp_q        <= resp_d;
            resp_stable_q <= resp_stable_d;
            resp_ones_q   <= resp_ones_d;
        end
    end

    assign chal_ready  = chal_ready_q;
    assign sel         = sel_q;
    assign arb_clr     = arb_clr_q;
    assign launch      = launch_q;
    assign resp_valid  = resp_valid_q;
    assign resp        = resp_q;
    assign resp_stable = resp_stable_q;
    assign resp_ones   = resp_ones_q;
    assign resp_raw    = raw_q;

endmodule

// File: tb/tb_xor_puf_eval_ctrl.sv
// Bench for xor_puf_eval_ctrl at default parameters.
// A cycle-position model predicts the outputs, and a compare loop checks them on every
// negedge. Directed literals pin the model.
module tb_xor_puf_eval_ctrl;

    localparam int N      = 128;
    localparam int K      = 4;
    localparam int SETTLE = 8;
    localparam int EVALS  = 5;
    localparam int RL     = SETTLE + 3;
    localparam int TOTAL  = EVALS * RL;

    logic           clk = 1'b0;
    logic           reset;
    logic           chal_valid;
    logic           chal_ready;
    logic [N-1:0]   chal;
    logic [N-1:0]   sel;
    logic           arb_clr;
    logic           launch;
    logic [K-1:0]   arb;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp;
    logic           resp_stable;
    logic [2:0]     resp_ones;
    logic [K-1:0]   resp_raw;

    xor_puf_eval_ctrl #(
        .N(N), .K(K), .SETTLE(SETTLE), .EVALS(EVALS)
    ) dut (
        .clk(clk), .reset(reset),
        .chal_valid(chal_valid), .chal_ready(chal_ready), .chal(chal),
        .sel(sel), .arb_clr(arb_clr), .launch(launch), .arb(arb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp),
        .resp_stable(resp_stable), .resp_ones(resp_ones), .resp_raw(resp_raw)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 busy (m_cyc = cycle index since accept), 2 done.
    int           m_st;
    int           m_cyc;
    int           m_ones;
    logic [K-1:0] m_raw;
    logic [N-1:0] m_sel;

    // Track what the controller must be doing purely from elapsed cycles and inputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st   <= 0;
            m_cyc  <= 0;
            m_ones <= 0;
            m_raw  <= '0;
            m_sel  <= '0;
        end else begin
            case (m_st)
                0: if (chal_valid) begin
                    m_sel  <= chal;
                    m_st   <= 1;
                    m_cyc  <= 0;
                    m_ones <= 0;
                end
                1: begin
                    if (m_cyc % RL == RL - 1) begin
                        m_ones <= m_ones + ($countones(arb) % 2);
                        m_raw  <= arb;
                    end
                    if (m_cyc == TOTAL - 1) m_st <= 2;
                    else m_cyc <= m_cyc + 1;
                end
                default: if (resp_ready) m_st <= 0;
            endcase
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_launch = 0;
    int n_clr    = 0;

    logic [K-1:0]   pats [EVALS];
    logic [N-1:0]   cur_chal;
    int             l0, c0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("chal_ready", 128'(chal_ready), 128'(m_st == 0));
                chk("arb_clr", 128'(arb_clr), 128'(m_st == 1 && m_cyc % RL == 0));
                chk("launch", 128'(launch), 128'(m_st == 1 && m_cyc % RL == 1));
                chk("resp_valid", 128'(resp_valid), 128'(m_st == 2));
                chk("sel", 128'(sel), 128'(m_sel));
                if (m_st == 2) begin
                    chk("resp", 128'(resp), 128'(m_ones > EVALS / 2));
                    chk("resp_stable", 128'(resp_stable), 128'(m_ones == 0 || m_ones == EVALS));
                    chk("resp_ones", 128'(resp_ones), 128'(m_ones));
                    chk("resp_raw", 128'(resp_raw), 128'(m_raw));
                end
            end
            if (launch) n_launch++;
            if (arb_clr) n_clr++;
        end
    endtask

    // Offer a challenge and drive arb for every evaluation cycle; returns at the first DONE negedge.
    task automatic run_chal(input logic [N-1:0] c, input bit rnd, input bit noisy);
        chal_valid = 1'b1;
        chal       = c;
        arb        = rnd ? K'($urandom) : pats[0];
        @(negedge clk);
        chal_valid = 1'b0;
        for (int i = 0; i < TOTAL; i++) begin
            arb = rnd ? K'($urandom) : pats[i / RL];
            if (noisy) begin
                chal_valid = 1'($urandom);
                chal       = {$urandom, $urandom, $urandom, $urandom};
            end
            if (i == TOTAL - 1) chk("valid_not_early", 128'(resp_valid), 128'(0));
            @(negedge clk);
        end
        chal_valid = 1'b0;
        chk("latency_valid", 128'(resp_valid), 128'(1));
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("ready_after_hs", 128'(chal_ready), 128'(1));
    endtask

    initial begin
        reset      = 1'b0;
        chal_valid = 1'b0;
        chal       = '0;
        arb        = '0;
        resp_ready = 1'b0;
        fork
            compare_loop();
        join_none

        #3;
        chk("rst_sel", 128'(sel), 128'(0));
        chk("rst_launch", 128'(launch), 128'(0));
        chk("rst_clr", 128'(arb_clr), 128'(0));
        chk("rst_valid", 128'(resp_valid), 128'(0));
        chk("rst_resp", 128'(resp), 128'(0));
        chk("rst_stable", 128'(resp_stable), 128'(0));
        chk("rst_ones", 128'(resp_ones), 128'(0));
        chk("rst_raw", 128'(resp_raw), 128'(0));
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 128'(chal_ready), 128'(1));

        // Constant arb 0111 gives odd parity every round.
        for (int r = 0; r < EVALS; r++) pats[r] = 4'b0111;
        cur_chal = {16{8'hA5}};
        run_chal(cur_chal, 1'b0, 1'b0);
        chk("t1_resp", 128'(resp), 128'(1));
        chk("t1_ones", 128'(resp_ones), 128'(5));
        chk("t1_stable", 128'(resp_stable), 128'(1));
        chk("t1_sel", 128'(sel), 128'(cur_chal));
        finish_resp();

        // Alternating parity with a 20-cycle stall in DONE.
        pats[0] = 4'b0001; pats[1] = 4'b0000; pats[2] = 4'b0001;
        pats[3] = 4'b0000; pats[4] = 4'b0001;
        run_chal({16{8'hC3}}, 1'b0, 1'b0);
        chk("t2_resp", 128'(resp), 128'(1));
        chk("t2_ones", 128'(resp_ones), 128'(3));
        chk("t2_stable", 128'(resp_stable), 128'(0));
        chk("t2_raw", 128'(resp_raw), 128'(4'b0001));
        repeat (20) @(negedge clk);
        chk("t3_hold_resp", 128'(resp), 128'(1));
        chk("t3_hold_ones", 128'(resp_ones), 128'(3));
        chk("t3_hold_stable", 128'(resp_stable), 128'(0));
        chk("t3_hold_raw", 128'(resp_raw), 128'(4'b0001));
        chk("t3_hold_valid", 128'(resp_valid), 128'(1));
        chk("t3_hold_ready", 128'(chal_ready), 128'(0));
        finish_resp();

        // Busy-time chal_valid noise must not disturb sel or pulse counts.
        for (int r = 0; r < EVALS; r++) pats[r] = 4'b0000;
        l0 = n_launch;
        c0 = n_clr;
        cur_chal = {4{32'h1234_5678}};
        run_chal(cur_chal, 1'b0, 1'b1);
        chk("t5_launches", 128'(n_launch - l0), 128'(5));
        chk("t5_clears", 128'(n_clr - c0), 128'(5));
        chk("t5_sel", 128'(sel), 128'(cur_chal));
        chk("t5_resp", 128'(resp), 128'(0));
        chk("t5_stable", 128'(resp_stable), 128'(1));
        finish_resp();

        // Reset during SETTLE of the second round.
        chal_valid = 1'b1;
        chal       = {16{8'h3C}};
        arb        = 4'b0111;
        @(negedge clk);
        chal_valid = 1'b0;
        repeat (16) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t4_launch", 128'(launch), 128'(0));
        chk("t4_clr", 128'(arb_clr), 128'(0));
        chk("t4_valid", 128'(resp_valid), 128'(0));
        chk("t4_sel", 128'(sel), 128'(0));
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t4_ready", 128'(chal_ready), 128'(1));
        for (int r = 0; r < EVALS; r++) pats[r] = 4'b1011;
        run_chal({16{8'h5A}}, 1'b0, 1'b0);
        chk("t4_resp", 128'(resp), 128'(1));
        chk("t4_ones", 128'(resp_ones), 128'(5));
        finish_resp();

        // Random arb every cycle; the model checks the sampling point and vote.
        for (int t = 0; t < 100; t++) begin
            run_chal({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
            resp_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            finish_resp();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
